// File: rtl/terrain_pkg.sv
// terrain_pkg: shared terrain memory geometry, column word type and carver FSM states.
//   COL_BITS  bits per terrain column word (bit i = screen row i, 1 = solid)
//   SCREEN_W  number of valid column addresses
//   R_W       crater radius width
//   RD_LAT    terrain read latency in clocks
package terrain_pkg;
    localparam int COL_BITS = 512;
    localparam int SCREEN_W = 640;
    localparam int R_W      = 6;
    localparam int RD_LAT   = 1;

    typedef logic [COL_BITS-1:0] column_t;

    typedef enum logic [2:0] {
        IDLE, SETUP, HCALC, READ, WAIT, WRITE, NEXT, DONE
    } carve_state_t;
endpackage

// File: rtl/crater_mask_gen.sv
// crater_mask_gen: combinational clear mask for one column, mask[i]=1 iff lo<=i<=hi.
//   lo    in   11        first row to clear (values >= COL_BITS yield an empty mask)
//   hi    in   11        last row to clear, already clipped to COL_BITS-1
//   mask  out  column_t  rows to clear
module crater_mask_gen
    import terrain_pkg::*;
(
    input  logic [10:0] lo,
    input  logic [10:0] hi,
    output column_t     mask
);
    // Ones from lo upward intersected with ones from hi downward; lo>hi leaves nothing.
    assign mask = ({COL_BITS{1'b1}} << lo) & ({COL_BITS{1'b1}} >> (11'(COL_BITS - 1) - hi));
endmodule

// File: rtl/crater_carver.sv
// crater_carver: carves a circular crater into the terrain bitmap by read-modify-write
// of each affected column, columns processed in ascending order.
//   clk          in   1         system clock
//   reset_n      in   1         asynchronous reset, active low
//   start        in   1         crater request, sampled only when idle
//   bomb_x       in   10        crater centre column
//   bomb_y       in   10        crater centre row
//   radius       in   R_W       crater radius in pixels
//   busy         out  1         high from the cycle after an accepted start through DONE
//   done         out  1         one-cycle completion pulse
//   mem_addr     out  10        terrain column address (read and write)
//   mem_rd_data  in   column_t  column word, valid RD_LAT clocks after mem_addr
//   mem_wr_data  out  column_t  modified column word
//   mem_we       out  1         write strobe, one cycle per written column
module crater_carver
    import terrain_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  logic [9:0]     bomb_x,
    input  logic [9:0]     bomb_y,
    input  logic [R_W-1:0] radius,
    output logic           busy,
    output logic           done,
    output logic [9:0]     mem_addr,
    input  column_t        mem_rd_data,
    output column_t        mem_wr_data,
    output logic           mem_we
);
    carve_state_t       state;
    logic [9:0]         cx, cy;
    logic [R_W-1:0]     r, h, dx_mag;
    logic signed [11:0] dx, col, lo_s;
    logic [11:0]        hi_s;
    logic [12:0]        h_sq, dx_sq, r_sq;
    logic [10:0]        lo, hi;
    logic [3:0]         wcnt;
    column_t            mask;

    assign col    = $signed({2'b00, cx}) + dx;
    assign dx_mag = R_W'(dx[11] ? -dx : dx);
    // 13-bit squares: 63*63*2 = 7938 fits without truncation.
    assign h_sq   = 13'(h) * 13'(h);
    assign dx_sq  = 13'(dx_mag) * 13'(dx_mag);
    assign r_sq   = 13'(r) * 13'(r);
    assign lo_s   = $signed({2'b00, cy}) - $signed({6'b0, h});
    assign hi_s   = {2'b00, cy} + {6'b0, h};
    assign lo     = lo_s[11] ? 11'd0 : lo_s[10:0];
    assign hi     = (hi_s > 12'(COL_BITS - 1)) ? 11'(COL_BITS - 1) : hi_s[10:0];

    crater_mask_gen u_mask (
        .lo   (lo),
        .hi   (hi),
        .mask (mask)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            cx          <= '0;
            cy          <= '0;
            r           <= '0;
            h           <= '0;
            dx          <= '0;
            wcnt        <= '0;
        end else begin
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cx    <= bomb_x;
                    cy    <= bomb_y;
                    r     <= radius;
                    dx    <= -$signed({6'b0, radius});
                    busy  <= 1'b1;
                    state <= SETUP;
                end
                SETUP: if (col[11] || col[10:0] >= 11'(SCREEN_W)) state <= NEXT;
                       else begin
                           h     <= r;
                           state <= HCALC;
                       end
                // Shrink the half-height until the point lies on or inside the circle.
                HCALC: if (h_sq + dx_sq > r_sq) h <= h - 1'b1;
                       else state <= READ;
                READ: begin
                    mem_addr <= col[9:0];
                    wcnt     <= '0;
                    state    <= WAIT;
                end
                // One cycle for the address to reach the memory, then RD_LAT cycles of latency;
                // the masked word is registered directly so WRITE presents it with mem_we.
                WAIT: if (wcnt == 4'(RD_LAT)) begin
                    mem_wr_data <= mem_rd_data & ~mask;
                    mem_we      <= 1'b1;
                    state       <= WRITE;
                end else wcnt <= wcnt + 1'b1;
                WRITE: state <= NEXT;
                NEXT: if (dx == $signed({6'b0, r})) begin
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    dx    <= dx + 12'sd1;
                    state <= SETUP;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_crater_carver.sv
// tb_crater_carver: self-checking bench for crater_carver with a registered terrain memory model.
module tb_crater_carver;
    import terrain_pkg::*;

    logic           clk = 1'b0;
    logic           reset_n = 1'b0;
    logic           start = 1'b0;
    logic [9:0]     bomb_x = '0;
    logic [9:0]     bomb_y = '0;
    logic [R_W-1:0] radius = '0;
    logic           busy, done, mem_we;
    logic [9:0]     mem_addr;
    column_t        mem_rd_data, mem_wr_data;

    column_t mem [SCREEN_W];
    column_t init_mem [SCREEN_W];
    column_t model [SCREEN_W];
    logic    load = 1'b0;
    int      wr_log[$];
    int      exp_cols[$];
    int      done_cnt = 0;
    int      checks = 0;
    int      failures = 0;

    always #10 clk = ~clk;

    crater_carver dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .bomb_x      (bomb_x),
        .bomb_y      (bomb_y),
        .radius      (radius),
        .busy        (busy),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_data (mem_wr_data),
        .mem_we      (mem_we)
    );

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < SCREEN_W; i++) mem[i] <= init_mem[i];
        end else if (mem_we && mem_addr < 10'(SCREEN_W)) begin
            mem[mem_addr] <= mem_wr_data;
        end
        mem_rd_data <= (mem_addr < 10'(SCREEN_W)) ? mem[mem_addr] : '0;
    end

    always @(negedge clk) begin
        if (mem_we) wr_log.push_back(int'(mem_addr));
        if (done) done_cnt++;
    end

    task automatic load_terrain(input bit rnd);
        for (int i = 0; i < SCREEN_W; i++) begin
            for (int w = 0; w < COL_BITS / 32; w++)
                init_mem[i][w*32 +: 32] = rnd ? 32'($urandom()) : 32'hFFFF_FFFF;
            model[i] = init_mem[i];
        end
        @(negedge clk) load = 1'b1;
        @(negedge clk) load = 1'b0;
    endtask

    // Reference: for each in-range column, the tallest half-height that stays inside the circle.
    task automatic model_carve(input int x, input int y, input int r);
        exp_cols.delete();
        for (int dx = -r; dx <= r; dx++) begin
            int c, h;
            c = x + dx;
            if (c < 0 || c >= SCREEN_W) continue;
            h = 0;
            while ((h + 1) * (h + 1) + dx * dx <= r * r) h++;
            exp_cols.push_back(c);
            for (int i = y - h; i <= y + h; i++)
                if (i >= 0 && i < COL_BITS) model[c][i] = 1'b0;
        end
    endtask

    task automatic crater(input int x, input int y, input int r, input string name, input int extra_at);
        int wbase, dbase, n, bad, first;
        model_carve(x, y, r);
        wbase = wr_log.size();
        dbase = done_cnt;
        @(negedge clk);
        bomb_x = 10'(x); bomb_y = 10'(y); radius = R_W'(r); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_start: got %b exp 1", name, busy);
        end
        if (extra_at > 0) begin
            repeat (extra_at) @(negedge clk);
            bomb_x = 10'd10; bomb_y = 10'd10; radius = R_W'(5); start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (done !== 1'b1 && n < 30000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s done_timeout: no done within %0d cycles", name, n);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL %s idle_after_done: busy=%b done=%b exp 0 0", name, busy, done);
        end
        repeat (4) @(negedge clk);
        checks++;
        if (done_cnt - dbase != 1) begin
            failures++;
            $display("FAIL %s done_pulses: got %0d exp 1", name, done_cnt - dbase);
        end
        checks++;
        bad = (wr_log.size() - wbase != exp_cols.size()) ? 1 : 0;
        for (int i = 0; bad == 0 && i < exp_cols.size(); i++)
            if (wr_log[wbase + i] != exp_cols[i]) bad = 1;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s write_cols: got %0d writes (first addr %0d) exp %0d writes (first addr %0d)",
                     name, wr_log.size() - wbase, (wr_log.size() > wbase) ? wr_log[wbase] : -1,
                     exp_cols.size(), (exp_cols.size() > 0) ? exp_cols[0] : -1);
        end
        bad = 0;
        first = -1;
        for (int i = 0; i < SCREEN_W; i++)
            if (mem[i] !== model[i]) begin
                bad++;
                if (first < 0) first = i;
            end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL %s terrain: %0d cols differ, col %0d got %h exp %h",
                     name, bad, first, mem[first], model[first]);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 10'd0 || mem_wr_data !== '0) begin
            failures++;
            $display("FAIL reset_outputs: busy=%b done=%b we=%b addr=%0d wr_nonzero=%b exp all 0",
                     busy, done, mem_we, mem_addr, |mem_wr_data);
        end
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: busy=%b we=%b exp 0 0", busy, mem_we);
        end
    endtask

    task automatic test_single_pixel();
        column_t expw;
        load_terrain(1'b0);
        crater(100, 200, 0, "r0", 0);
        expw = '1;
        expw[200] = 1'b0;
        checks++;
        if (mem[100] !== expw) begin
            failures++;
            $display("FAIL r0_col100: got %h exp %h", mem[100], expw);
        end
    endtask

    task automatic test_small_crater();
        column_t expw;
        load_terrain(1'b0);
        crater(320, 240, 3, "r3", 0);
        expw = '1;
        expw[240] = 1'b0;
        checks++;
        if (mem[317] !== expw) begin
            failures++;
            $display("FAIL r3_col317: got %h exp %h", mem[317], expw);
        end
        expw = '1;
        for (int i = 238; i <= 242; i++) expw[i] = 1'b0;
        checks++;
        if (mem[318] !== expw) begin
            failures++;
            $display("FAIL r3_col318: got %h exp %h", mem[318], expw);
        end
    endtask

    task automatic test_edges();
        load_terrain(1'b0);
        crater(0, 10, 3, "left_edge", 0);
        crater(639, 100, 2, "right_edge", 0);
        crater(50, 2, 5, "top_clip", 0);
        checks++;
        if (mem[50][7:0] !== 8'h00 || mem[50][8] !== 1'b1) begin
            failures++;
            $display("FAIL top_clip_bits: got low9=%b exp 100000000", mem[50][8:0]);
        end
        crater(200, 700, 40, "below_word", 0);
        crater(600, 511, 63, "bottom_clip", 0);
    endtask

    task automatic test_start_while_busy();
        load_terrain(1'b1);
        crater(320, 240, 3, "busy_start", 5);
        crater(12, 12, 4, "idle_start", 0);
    endtask

    task automatic test_async_reset();
        int wbase;
        load_terrain(1'b0);
        wbase = wr_log.size();
        @(negedge clk);
        bomb_x = 10'd300; bomb_y = 10'd100; radius = R_W'(63); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #3 reset_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: busy=%b done=%b we=%b exp 0 0 0", busy, done, mem_we);
        end
        @(negedge clk);
        reset_n = 1'b1;
        checks++;
        if (wr_log.size() != wbase) begin
            failures++;
            $display("FAIL async_reset_writes: got %0d writes exp 0", wr_log.size() - wbase);
        end
        crater(320, 240, 3, "after_reset", 0);
    endtask

    task automatic test_back_to_back();
        load_terrain(1'b1);
        for (int k = 0; k < 6; k++)
            crater(int'($urandom_range(0, SCREEN_W - 1)), int'($urandom_range(0, 700)),
                   int'($urandom_range(0, 63)), $sformatf("rand%0d", k), 0);
    endtask

    initial begin
        test_reset();
        test_single_pixel();
        test_small_crater();
        test_edges();
        test_start_while_busy();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
